store_datapath: RTL
===================

// Module: store_datapath
// PURPOSE
//  Squeeze-side counterpart of the load stage. Accepts full rate blocks from the permutation core in parallel and serialises them into w-bit little-endian output words.
//  Counts down the requested output size in bits and requests further squeeze blocks until the size is exhausted.
//  Sits between the permutation/squeeze stage and the external output interface.
// PARAMETERS
//  W      default w (64)             output word width; must equal keccak_pkg::w
//  RATE   default RATE_SHAKE128      width of the parallel block input (1344)
// PORTS
//  clk              in   1      single clock
//  rst              in   1      asynchronous, active-high reset
//  size_load        in   1      pulse: latch output_size and operation_mode, start a job
//  output_size      in   32     requested output length in bits (bits [2:0] ignored)
//  operation_mode   in   2      SHAKE128_MODE_VEC / SHAKE256_MODE_VEC
//  rate_output      in   RATE   squeezed block; word 0 = rate_output[W-1:0]
//  block_valid      in   1      rate_output is valid
//  block_ready      out  1      stage can accept a block (high only in WAIT_BLOCK)
//  squeeze_req      out  1      1-cycle pulse: core must produce the next block
//  data_out         out  W      serialised word, byte-swapped by EndianSwitcher
//  data_out_valid   out  1      data_out is valid
//  data_out_ready   in   1      downstream accepts data_out
//  data_out_bytes   out  4      valid bytes in data_out (1..8)
//  done             out  1      1-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs, counters and the PISO clear to 0. A reset mid-job abandons it immediately; no done pulse is produced.
//  FSM states:
//   IDLE -> WAIT_BLOCK on size_load when output_size[31:3] != 0.
//   IDLE: size_load with output_size[31:3] == 0 pulses done on the next cycle and stays IDLE.
//   WAIT_BLOCK: block_ready=1. On block_valid&&block_ready, the PISO loads rate_output and word_cnt = depth-1, where depth = 21 (SHAKE128) or 17 (SHAKE256, default 21). Next state SEND.
//   SEND: data_out_valid=1. A beat is data_out_valid&&data_out_ready. Each beat shifts the PISO one word and sets remaining -= min(64, remaining).
//     If remaining <= 64 at the beat: go to IDLE and pulse done next cycle.
//     Else if word_cnt == 0: go to WAIT_BLOCK and pulse squeeze_req next cycle.
//     Else: word_cnt -= 1.
//  Latency: first data_out_valid arrives 1 cycle after the block handshake. Throughput is 1 word/cycle under continuous ready.
//  data_out, data_out_bytes and data_out_valid hold stable while valid && !ready.
//  data_out_bytes = 8, except on the final word, where it is remaining[5:3] (0 maps to 8).
//  size_load outside IDLE is ignored. block_valid outside WAIT_BLOCK is ignored and no block is consumed.
//  Unused upper words of a SHAKE256 block (words 17..20) are never emitted.
//  remaining is a 32-bit register loaded with {output_size[31:3],3'b0}. It never underflows.
// CONFIGURATION
//  Macro STORE_ZERO_TAIL_EN.
//  Defined: on the final word, bytes at index >= data_out_bytes are forced to 0, applied after the endian swap.
//  Undefined: the final word carries the raw squeezed bytes; the consumer relies on data_out_bytes only.
// STRUCTURE
//  keccak_pkg holds w, RATE_SHAKE128/256, the mode vectors, EndianSwitcher and a new store_state_t enum {IDLE, WAIT_BLOCK, SEND}.
//  One sub-module, piso_buffer (WIDTH=W, DEPTH=RATE/W), with ports load/shift/data_in/data_out. It mirrors sipo_buffer.
//  remaining and word_cnt reuse the existing size_counter and countern blocks.
// TESTING
//  1 SHAKE128, output_size=256, ready=1 -> 4 beats, data_out_bytes=8 each, done 1 cycle after beat 4, squeeze_req never pulses.
//  2 SHAKE128, output_size=1344*2 -> 21 beats, squeeze_req pulse, second block handshake, 21 beats, done; words match byte-swapped blocks.
//  3 SHAKE256, output_size=1344 -> 17 beats, squeeze_req, 4 beats from block 2, done. Words 17..20 of block 1 never appear.
//  4 output_size=200 -> 4 beats; last data_out_bytes=1. With STORE_ZERO_TAIL_EN, bytes 1..7 = 0; without it, raw bytes.
//  5 ready toggled randomly, then reset asserted mid-SEND -> data_out stable while stalled; after reset: IDLE, block_ready=0, no done.
//  6 output_size=0 -> done next cycle, block_ready never asserts. A size_load during SEND changes nothing.

Source files
------------

// File: rtl/store_datapath_pkg.sv
// Shared constants, mode encodings, state type and byte-swap helper for the squeeze-side store stage.
package store_datapath_pkg;

    localparam int WORD_W         = 64;
    localparam int RATE_SHAKE128  = 1344;
    localparam int RATE_SHAKE256  = 1088;
    localparam int DEPTH_SHAKE128 = RATE_SHAKE128 / WORD_W;
    localparam int DEPTH_SHAKE256 = RATE_SHAKE256 / WORD_W;

    localparam logic [1:0] SHAKE128_MODE_VEC = 2'b01;
    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        SEND
    } store_state_t;

    // Reverses byte order so the lane's least significant byte leaves first.
    function automatic logic [WORD_W-1:0] endian_switch(input logic [WORD_W-1:0] x);
        logic [WORD_W-1:0] y;
        y = '0;
        for (int i = 0; i < WORD_W / 8; i++) begin
            y[8*i +: 8] = x[WORD_W - 8 - 8*i +: 8];
        end
        return y;
    endfunction

endpackage

// File: rtl/store_datapath_piso.sv
// piso_buffer: parallel-in serial-out word buffer; word 0 of the loaded block is presented first.
module piso_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 21
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   shift_i,
    input  logic [WIDTH*DEPTH-1:0] data_in_i,
    output logic [WIDTH-1:0]       data_out_o
);

    logic [WIDTH*DEPTH-1:0] buf_q;

    // Load wins over shift; shifting pulls zeros into the top word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q <= '0;
        end else if (load_i) begin
            buf_q <= data_in_i;
        end else if (shift_i) begin
            buf_q <= {{WIDTH{1'b0}}, buf_q[WIDTH*DEPTH-1:WIDTH]};
        end
    end

    assign data_out_o = buf_q[WIDTH-1:0];

endmodule

// File: rtl/store_datapath.sv
// Serialises squeezed rate blocks into byte-swapped output words until the requested size is exhausted.
// Optional macro STORE_ZERO_TAIL_EN zeroes the unused bytes of the final word.
module store_datapath
    import store_datapath_pkg::*;
#(
    parameter int W    = WORD_W,
    parameter int RATE = RATE_SHAKE128
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            size_load_i,
    input  logic [31:0]     output_size_i,
    input  logic [1:0]      operation_mode_i,
    input  logic [RATE-1:0] rate_output_i,
    input  logic            block_valid_i,
    output logic            block_ready_o,
    output logic            squeeze_req_o,
    output logic [W-1:0]    data_out_o,
    output logic            data_out_valid_o,
    input  logic            data_out_ready_i,
    output logic [3:0]      data_out_bytes_o,
    output logic            done_o
);

    store_state_t state_q, state_d;
    logic [31:0]  remaining_q, remaining_d;
    logic [4:0]   word_cnt_q, word_cnt_d;
    logic [1:0]   mode_q, mode_d;
    logic         done_q, done_d;
    logic         squeeze_q, squeeze_d;
    logic         piso_load, piso_shift, last_word;
    logic [W-1:0] piso_word, swapped_word;
    logic [3:0]   final_bytes;
    logic         unused_size_low;

    assign unused_size_low = ^output_size_i[2:0];

    piso_buffer #(
        .WIDTH (W),
        .DEPTH (RATE / W)
    ) u_piso (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (piso_load),
        .shift_i    (piso_shift),
        .data_in_i  (rate_output_i),
        .data_out_o (piso_word)
    );

    assign last_word    = (remaining_q <= 32'(W));
    assign final_bytes  = (remaining_q[5:3] == 3'd0) ? 4'd8 : {1'b0, remaining_q[5:3]};
    assign swapped_word = endian_switch(piso_word);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            word_cnt_q  <= '0;
            mode_q      <= '0;
            done_q      <= 1'b0;
            squeeze_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            word_cnt_q  <= word_cnt_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
            squeeze_q   <= squeeze_d;
        end
    end

    // done and squeeze_req are registered so each appears the cycle after its triggering event.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        word_cnt_d  = word_cnt_q;
        mode_d      = mode_q;
        done_d      = 1'b0;
        squeeze_d   = 1'b0;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        case (state_q)
            IDLE: begin
                if (size_load_i) begin
                    remaining_d = {output_size_i[31:3], 3'b000};
                    mode_d      = operation_mode_i;
                    if (output_size_i[31:3] != 29'd0) begin
                        state_d = WAIT_BLOCK;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WAIT_BLOCK: begin
                if (block_valid_i) begin
                    piso_load  = 1'b1;
                    word_cnt_d = (mode_q == SHAKE256_MODE_VEC) ? 5'(DEPTH_SHAKE256 - 1)
                                                               : 5'(DEPTH_SHAKE128 - 1);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (data_out_ready_i) begin
                    piso_shift = 1'b1;
                    if (last_word) begin
                        remaining_d = '0;
                        state_d     = IDLE;
                        done_d      = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 32'(W);
                        if (word_cnt_q == 5'd0) begin
                            state_d   = WAIT_BLOCK;
                            squeeze_d = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q - 5'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign block_ready_o    = (state_q == WAIT_BLOCK);
    assign data_out_valid_o = (state_q == SEND);
    assign data_out_bytes_o = !data_out_valid_o ? 4'd0 : (last_word ? final_bytes : 4'd8);
    assign squeeze_req_o    = squeeze_q;
    assign done_o           = done_q;

`ifdef STORE_ZERO_TAIL_EN
    always_comb begin
        data_out_o = swapped_word;
        if (data_out_valid_o && last_word) begin
            for (int i = 0; i < W / 8; i++) begin
                if (i >= int'(data_out_bytes_o)) begin
                    data_out_o[8*i +: 8] = 8'h00;
                end
            end
        end
    end
`else
    assign data_out_o = swapped_word;
`endif

endmodule
